// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control unit: owns the state register, sequences fetch/decode/execute/memory/writeback
// and decodes datapath strobes from state. Optional retired-instruction counter under PERF_CNT_EN.
module multicycle_ctrl_fsm #(
  parameter int OPC_W       = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             mem_ready,
  output logic [4:0]       state,
  output logic             wpc,
  output logic             rpc,
  output logic             wmar,
  output logic             rmar,
  output logic             wmdr,
  output logic             rmdr,
  output logic             rm,
  output logic             wmem,
  output logic             wir,
  output logic             wreg,
  output logic             rreg,
  output logic [1:0]       reg_sel,
  output logic             wt,
  output logic             rt,
  output logic             ldf,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             fault
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [4:0] {
    S_FETCH0 = 5'd1,  S_FETCH1 = 5'd2,  S_FETCH2 = 5'd3,  S_DECODE = 5'd4,
    S_ALU    = 5'd5,  S_WB     = 5'd6,  S_ADDR   = 5'd7,  S_MEMRD  = 5'd8,
    S_LDWB   = 5'd9,  S_STMDR  = 5'd10, S_MEMWR  = 5'd11, S_BR     = 5'd12,
    S_HALT   = 5'd13, S_FAULT  = 5'd14
  } state_t;

  state_t           state_reg, state_next;
  logic [OPC_W-1:0] op_reg, op_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             timeout_hit;
  logic             br_taken;

  // Expiry is judged on the cycle that would be the MEM_TIMEOUT-th wait without ready.
  assign timeout_hit = (to_cnt_reg == TO_W'(MEM_TIMEOUT - 1));
  assign state       = state_reg;

  always_comb begin
    unique case (op_reg[1:0])
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = flag_z;
      2'b10:   br_taken = flag_n;
      default: br_taken = ~flag_z;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_FETCH0;
      op_reg     <= '0;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    to_cnt_next = '0;
    wpc = 1'b0; rpc = 1'b0; wmar = 1'b0; rmar = 1'b0;
    wmdr = 1'b0; rmdr = 1'b0; rm = 1'b0; wmem = 1'b0;
    wir = 1'b0; wreg = 1'b0; rreg = 1'b0; reg_sel = 2'b00;
    wt = 1'b0; rt = 1'b0; ldf = 1'b0; alu_op = 3'b101;
    halted = 1'b0; fault = 1'b0;
    case (state_reg)
      S_FETCH0: begin
        rpc = 1'b1; wmar = 1'b1;
        state_next = S_FETCH1;
      end
      S_FETCH1: begin
        rmar = 1'b1; rm = 1'b1;
        if (mem_ready) begin
          wmdr = 1'b1;
          state_next = S_FETCH2;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_FETCH2: begin
        rmdr = 1'b1; wir = 1'b1; rpc = 1'b1; alu_op = 3'b100; wpc = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        rreg = 1'b1; wt = 1'b1;
        op_next = opcode;
        unique case (opcode[OPC_W-1:OPC_W-2])
          2'b00:   state_next = S_ALU;
          2'b01:   state_next = S_ADDR;
          2'b10:   state_next = S_BR;
          default: state_next = (&opcode) ? S_HALT : S_FETCH0;
        endcase
      end
      S_ALU: begin
        rt = 1'b1; rreg = 1'b1; reg_sel = 2'b01; alu_op = op_reg[2:0]; ldf = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        wreg = 1'b1; reg_sel = 2'b01;
        state_next = S_FETCH0;
      end
      S_ADDR: begin
        rt = 1'b1; wmar = 1'b1;
        state_next = op_reg[3] ? S_STMDR : S_MEMRD;
      end
      S_MEMRD: begin
        rmar = 1'b1; rm = 1'b1;
        if (mem_ready) begin
          wmdr = 1'b1;
          state_next = S_LDWB;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_LDWB: begin
        rmdr = 1'b1; wreg = 1'b1; reg_sel = 2'b01;
        state_next = S_FETCH0;
      end
      S_STMDR: begin
        rreg = 1'b1; reg_sel = 2'b01; wmdr = 1'b1;
        state_next = S_MEMWR;
      end
      S_MEMWR: begin
        rmar = 1'b1; rmdr = 1'b1; wmem = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH0;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_BR: begin
        // Taken branch adds the T offset to PC; untaken simply refetches.
        if (br_taken) begin
          rpc = 1'b1; rt = 1'b1; alu_op = 3'b000; wpc = 1'b1;
        end
        state_next = S_FETCH0;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: state_next = S_FAULT;
    endcase
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (state_next == S_FETCH0) &&
                  (state_reg == S_WB || state_reg == S_LDWB || state_reg == S_MEMWR ||
                   state_reg == S_BR || state_reg == S_DECODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle compare against a spec-level model plus
// directed instruction scenarios with hand-computed traces.
module tb_multicycle_ctrl_fsm;
  localparam int OPC_W = 6, MEM_TIMEOUT = 15, TO_W = 4, CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [OPC_W-1:0] opcode = '0;
  logic flag_z = 1'b0, flag_n = 1'b0, mem_ready = 1'b0;
  logic [4:0] state;
  logic wpc, rpc, wmar, rmar, wmdr, rmdr, rm, wmem, wir, wreg, rreg, wt, rt, ldf, halted, fault;
  logic [1:0] reg_sel;
  logic [2:0] alu_op;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt;
`endif

  multicycle_ctrl_fsm #(.OPC_W(OPC_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
    .mem_ready(mem_ready), .state(state), .wpc(wpc), .rpc(rpc), .wmar(wmar), .rmar(rmar),
    .wmdr(wmdr), .rmdr(rmdr), .rm(rm), .wmem(wmem), .wir(wir), .wreg(wreg), .rreg(rreg),
    .reg_sel(reg_sel), .wt(wt), .rt(rt), .ldf(ldf), .alu_op(alu_op), .halted(halted), .fault(fault)
`ifdef PERF_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: phase number, latched opcode, wait length, retired count.
  int          m_state;
  logic [5:0]  m_op;
  int          m_wait;
  logic [15:0] m_cnt;

  function automatic bit is_wait(input int s);
    return (s == 2 || s == 8 || s == 11);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 1; m_wait = 0; m_cnt = '0; m_op = '0;
    end else begin
      int nxt;
      case (m_state)
        1: nxt = 2;
        2, 8, 11: begin
          if (mem_ready) nxt = (m_state == 2) ? 3 : (m_state == 8) ? 9 : 1;
          else if (m_wait + 1 >= MEM_TIMEOUT) nxt = 14;
          else nxt = m_state;
        end
        3: nxt = 4;
        4: begin
          m_op = opcode;
          case (opcode[5:4])
            2'd0: nxt = 5;
            2'd1: nxt = 7;
            2'd2: nxt = 12;
            default: nxt = (opcode == 6'h3f) ? 13 : 1;
          endcase
        end
        5: nxt = 6;
        7: nxt = m_op[3] ? 10 : 8;
        10: nxt = 11;
        6, 9, 12: nxt = 1;
        13: nxt = 13;
        default: nxt = 14;
      endcase
      if (nxt == 1 && m_state != 1) m_cnt = m_cnt + 16'd1;
      m_wait = (nxt == m_state && is_wait(m_state)) ? m_wait + 1 : 0;
      m_state = nxt;
    end
  end

  function automatic logic [20:0] exp_out(input int s, input logic [5:0] op, input logic z, input logic n,
                                          input logic rdy);
    logic e_wpc, e_rpc, e_wmar, e_rmar, e_wmdr, e_rmdr, e_rm, e_wmem, e_wir, e_wreg, e_rreg;
    logic e_wt, e_rt, e_ldf, e_halt, e_fault, taken;
    logic [1:0] e_sel;
    logic [2:0] e_alu;
    {e_wpc, e_rpc, e_wmar, e_rmar, e_wmdr, e_rmdr, e_rm, e_wmem, e_wir, e_wreg, e_rreg} = '0;
    {e_wt, e_rt, e_ldf, e_halt, e_fault} = '0;
    e_sel = 2'b00; e_alu = 3'b101;
    taken = (op[1:0] == 2'b00) || (op[1:0] == 2'b01 && z) || (op[1:0] == 2'b10 && n) ||
            (op[1:0] == 2'b11 && !z);
    case (s)
      1: begin e_rpc = 1; e_wmar = 1; end
      2, 8: begin e_rmar = 1; e_rm = 1; e_wmdr = rdy; end
      3: begin e_rmdr = 1; e_wir = 1; e_rpc = 1; e_alu = 3'b100; e_wpc = 1; end
      4: begin e_rreg = 1; e_wt = 1; end
      5: begin e_rt = 1; e_rreg = 1; e_sel = 2'b01; e_alu = op[2:0]; e_ldf = 1; end
      6: begin e_wreg = 1; e_sel = 2'b01; end
      7: begin e_rt = 1; e_wmar = 1; end
      9: begin e_rmdr = 1; e_wreg = 1; e_sel = 2'b01; end
      10: begin e_rreg = 1; e_sel = 2'b01; e_wmdr = 1; end
      11: begin e_rmar = 1; e_rmdr = 1; e_wmem = 1; end
      12: if (taken) begin e_rpc = 1; e_rt = 1; e_alu = 3'b000; e_wpc = 1; end
      13: e_halt = 1;
      14: e_fault = 1;
      default: ;
    endcase
    return {e_wpc, e_rpc, e_wmar, e_rmar, e_wmdr, e_rmdr, e_rm, e_wmem, e_wir, e_wreg, e_rreg,
            e_sel, e_wt, e_rt, e_ldf, e_alu, e_halt, e_fault};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("state", 32'(state), 32'(m_state));
      check("strobes",
            32'({wpc, rpc, wmar, rmar, wmdr, rmdr, rm, wmem, wir, wreg, rreg,
                 reg_sel, wt, rt, ldf, alu_op, halted, fault}),
            32'(exp_out(m_state, m_op, flag_z, flag_n, mem_ready)));
`ifdef PERF_CNT_EN
      check("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
`endif
    end
  end

  typedef struct {
    int st;
    logic [2:0] alu;
    logic ldf, wreg, wpc, rm, fault, halted;
  } snap_t;
  snap_t trace[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Runs from S_FETCH0 until the model returns to FETCH0 or a terminal state; records one snapshot per cycle.
  task automatic run_instr(input logic [5:0] op, input int fdly, input int mdly);
    int n = 0;
    trace.delete();
    do begin
      snap_t s;
      s.st = int'(state); s.alu = alu_op; s.ldf = ldf; s.wreg = wreg; s.wpc = wpc;
      s.rm = rm; s.fault = fault; s.halted = halted;
      trace.push_back(s);
      opcode = (m_state <= 4) ? op : ~op;
      if (is_wait(m_state)) mem_ready = (m_wait >= ((m_state == 2) ? fdly : mdly));
      else mem_ready = 1'($urandom);
      step();
      n++;
    end while (!(m_state == 1 || m_state == 13 || m_state == 14) && n < 60);
    check("cycle_budget", 32'(n < 60), 32'd1);
    $display("instr op=%b fdly=%0d mdly=%0d cycles=%0d end_state=%0d", op, fdly, mdly, n, m_state);
  endtask

  task automatic check_seq(input string name, input int exp[]);
    check({name, "_len"}, 32'(trace.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      check(name, 32'(trace[i].st), 32'(exp[i]));
  endtask

  initial begin
    int cnt;
    do_reset();
    check("reset_state", 32'(state), 32'd1);
    check("reset_alu_op", 32'(alu_op), 32'd5);
    check("reset_rpc_wmar", 32'({rpc, wmar, fault, halted}), 32'b1100);

    run_instr(6'b000011, 0, 0);
    check_seq("alu_seq", '{1, 2, 3, 4, 5, 6});
    check("alu_state", 32'(state), 32'd1);
    check("alu_op_or", 32'(trace[4].alu), 32'd3);
    check("alu_ldf", 32'(trace[4].ldf), 32'd1);
    check("wb_wreg", 32'(trace[5].wreg), 32'd1);

    run_instr(6'b010000, 0, 3);
    check_seq("ld_seq", '{1, 2, 3, 4, 7, 8, 8, 8, 8, 9});
    cnt = 0;
    foreach (trace[i]) if (trace[i].st == 8 && trace[i].rm) cnt++;
    check("ld_rm_cycles", 32'(cnt), 32'd4);
    check("ldwb_wreg", 32'(trace[9].wreg), 32'd1);

    run_instr(6'b011000, 2, 1);
    check_seq("st_seq", '{1, 2, 2, 2, 3, 4, 7, 10, 11, 11});

    flag_z = 1'b0;
    run_instr(6'b100001, 0, 0);
    check_seq("brz_nt_seq", '{1, 2, 3, 4, 12});
    check("brz_nt_wpc", 32'(trace[4].wpc), 32'd0);
    flag_z = 1'b1;
    run_instr(6'b100001, 0, 0);
    check("brz_t_wpc", 32'(trace[4].wpc), 32'd1);
    check("brz_t_alu", 32'(trace[4].alu), 32'd0);
    flag_n = 1'b1; flag_z = 1'b0;
    run_instr(6'b100010, 0, 0);
    check("brn_t_wpc", 32'(trace[4].wpc), 32'd1);
    run_instr(6'b100011, 0, 0);
    check("brnz_t_wpc", 32'(trace[4].wpc), 32'd1);
    flag_z = 1'b1; flag_n = 1'b0;
    run_instr(6'b100011, 0, 0);
    check("brnz_nt_wpc", 32'(trace[4].wpc), 32'd0);

    run_instr(6'b110101, 0, 0);
    check_seq("nop_seq", '{1, 2, 3, 4});

    run_instr(6'b110000, 14, 0);
    check("fetch_ready_last_len", 32'(trace.size()), 32'd18);
    check("fetch_ready_last_st", 32'(trace[16].st), 32'd3);

    run_instr(6'b110000, 100, 0);
    check("fetch_to_len", 32'(trace.size()), 32'd16);
    check("fetch_to_state", 32'(state), 32'd14);
    repeat (5) begin mem_ready = 1'b1; step(); end
    check("fault_held", 32'({fault, state}), 32'({1'b1, 5'd14}));
    do_reset();

    run_instr(6'b011000, 0, 100);
    check("memwr_to_state", 32'(state), 32'd14);
    do_reset();

    cnt = 0;
    while (m_state != 8 && cnt < 20) begin
      opcode = 6'b010000; mem_ready = 1'b1; step(); cnt++;
    end
    mem_ready = 1'b0;
    step(); step();
    check("memrd_wait_rm", 32'({state, rm}), 32'({5'd8, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd1);
    check("async_rst_rm", 32'(rm), 32'd0);
    check("async_rst_alu", 32'(alu_op), 32'd5);
    step();
    rst_n = 1'b1;

    run_instr(6'b111111, 0, 0);
    check_seq("halt_seq", '{1, 2, 3, 4});
    repeat (50) begin mem_ready = 1'($urandom); opcode = 6'($urandom); step(); end
    check("halt_held", 32'({halted, state}), 32'({1'b1, 5'd13}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
